// File: rtl/spi_slave_frontend.sv
// SPI mode-0 target front end: synchronises sclk/ncs/di into clk, deserialises MOSI
// bytes into a strobed stream and serialises response bytes onto an idle-high MISO.
module spi_slave_frontend #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [7:0]  IDLE_BYTE   = 8'hFF
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_sclk,
    input  logic       i_ncs,
    input  logic       i_di,
    output logic       o_do,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    output logic       o_rx_first,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ack,
    output logic       o_frame_start,
    output logic       o_frame_end,
    output logic       o_frame_abort,
    output logic       o_selected
);

    localparam int unsigned FLUSH_W   = $clog2(SYNC_STAGES + 2);
    localparam int unsigned FLUSH_MAX = SYNC_STAGES + 1;

    typedef enum logic {S_IDLE, S_ACTIVE} state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic [SYNC_STAGES-1:0] r_di_sync;
    logic                   r_sclk_d;
    logic                   r_ncs_d;
    logic [FLUSH_W-1:0]     r_flush_cnt;
    logic                   r_armed;

    logic w_sclk_s;
    logic w_ncs_s;
    logic w_di_s;
    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_ncs_rise;
    logic w_ncs_fall;

    state_t     r_state;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic       r_first;
    logic       r_end_pend;
    logic       r_do;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_rx_first;
    logic       r_tx_ack;
    logic       r_frame_start;
    logic       r_frame_end;
    logic       r_frame_abort;
    logic       r_selected;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
    assign w_di_s      = r_di_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_d;
    assign w_sclk_fall = ~w_sclk_s & r_sclk_d;
    assign w_ncs_rise  = w_ncs_s & ~r_ncs_d;
    assign w_ncs_fall  = ~w_ncs_s & r_ncs_d;

    // Synchronisers; arming waits for a genuinely high ncs so a frame is never joined mid-way
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_sclk_sync <= '0;
            r_ncs_sync  <= '1;
            r_di_sync   <= '0;
            r_sclk_d    <= 1'b0;
            r_ncs_d     <= 1'b1;
            r_flush_cnt <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], i_ncs};
            r_di_sync   <= {r_di_sync[SYNC_STAGES-2:0], i_di};
            r_sclk_d    <= w_sclk_s;
            r_ncs_d     <= w_ncs_s;
            if (r_flush_cnt != FLUSH_W'(FLUSH_MAX)) begin
                r_flush_cnt <= r_flush_cnt + FLUSH_W'(1);
            end else if (w_ncs_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Frame FSM, shift registers and registered outputs
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= 3'd0;
            r_rx_shift    <= 8'h00;
            r_tx_shift    <= IDLE_BYTE;
            r_first       <= 1'b0;
            r_end_pend    <= 1'b0;
            r_do          <= 1'b1;
            r_rx_data     <= 8'h00;
            r_rx_valid    <= 1'b0;
            r_rx_first    <= 1'b0;
            r_tx_ack      <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frame_abort <= 1'b0;
            r_selected    <= 1'b0;
        end else begin
            r_rx_valid    <= 1'b0;
            r_tx_ack      <= 1'b0;
            r_frame_start <= 1'b0;
            r_frame_end   <= 1'b0;
            r_frame_abort <= 1'b0;
            r_selected    <= ~w_ncs_s;
            r_do          <= (r_selected && r_state == S_ACTIVE) ? r_tx_shift[7] : 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (r_armed && w_ncs_fall) begin
                        r_state       <= S_ACTIVE;
                        r_frame_start <= 1'b1;
                        r_bit_cnt     <= 3'd0;
                        r_first       <= 1'b1;
                        r_end_pend    <= 1'b0;
                        if (i_tx_valid) begin
                            r_tx_shift <= i_tx_data;
                            r_tx_ack   <= 1'b1;
                        end else begin
                            r_tx_shift <= IDLE_BYTE;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (w_sclk_rise) begin
                        r_rx_shift <= {r_rx_shift[6:0], w_di_s};
                        r_bit_cnt  <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) begin
                            r_rx_data  <= {r_rx_shift[6:0], w_di_s};
                            r_rx_valid <= 1'b1;
                            r_rx_first <= r_first;
                            r_first    <= 1'b0;
                            if (i_tx_valid) begin
                                r_tx_shift <= i_tx_data;
                                r_tx_ack   <= 1'b1;
                            end else begin
                                r_tx_shift <= IDLE_BYTE;
                            end
                        end
                        // A coincident ncs rise is finished one clk after the byte
                        if (w_ncs_rise) begin
                            r_end_pend <= 1'b1;
                        end
                    end else if (w_ncs_rise || r_end_pend) begin
                        r_state       <= S_IDLE;
                        r_frame_end   <= 1'b1;
                        r_frame_abort <= (r_bit_cnt != 3'd0);
                        r_end_pend    <= 1'b0;
                    end else if (w_sclk_fall && r_bit_cnt != 3'd0) begin
                        r_tx_shift <= {r_tx_shift[6:0], 1'b1};
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_do          = r_do;
    assign o_rx_data     = r_rx_data;
    assign o_rx_valid    = r_rx_valid;
    assign o_rx_first    = r_rx_first;
    assign o_tx_ack      = r_tx_ack;
    assign o_frame_start = r_frame_start;
    assign o_frame_end   = r_frame_end;
    assign o_frame_abort = r_frame_abort;
    assign o_selected    = r_selected;

endmodule

// File: tb/tb_spi_slave_frontend.sv
// Directed bench for spi_slave_frontend: acts as the SPI master and counts strobes.
module tb_spi_slave_frontend;

    logic       clk = 1'b0;
    logic       rst;
    logic       sclk;
    logic       ncs;
    logic       di;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       o_do;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_first;
    logic       tx_ack;
    logic       frame_start;
    logic       frame_end;
    logic       frame_abort;
    logic       selected;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc = 0;
    int n_rxv = 0, n_ack = 0, n_fs = 0, n_fe = 0, n_fa = 0, n_fa_alone = 0;
    int rxv_cyc = 0, fe_cyc = 0;
    logic [7:0] last_rx = 8'h00;
    logic       last_first = 1'b0;

    int b_rxv, b_ack, b_fs, b_fe, b_fa, b_fa_alone;

    always #5 clk = ~clk;

    spi_slave_frontend #(.SYNC_STAGES(2), .IDLE_BYTE(8'hFF)) dut (
        .i_clk(clk), .i_reset(rst), .i_sclk(sclk), .i_ncs(ncs), .i_di(di),
        .o_do(o_do), .o_rx_data(rx_data), .o_rx_valid(rx_valid), .o_rx_first(rx_first),
        .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ack(tx_ack),
        .o_frame_start(frame_start), .o_frame_end(frame_end),
        .o_frame_abort(frame_abort), .o_selected(selected)
    );

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (rx_valid) begin
            n_rxv      <= n_rxv + 1;
            rxv_cyc    <= cyc;
            last_rx    <= rx_data;
            last_first <= rx_first;
        end
        if (tx_ack)      n_ack <= n_ack + 1;
        if (frame_start) n_fs  <= n_fs + 1;
        if (frame_end) begin
            n_fe   <= n_fe + 1;
            fe_cyc <= cyc;
        end
        if (frame_abort) n_fa <= n_fa + 1;
        if (frame_abort && !frame_end) n_fa_alone <= n_fa_alone + 1;
    end

    task automatic snap();
        b_rxv = n_rxv; b_ack = n_ack; b_fs = n_fs; b_fe = n_fe; b_fa = n_fa;
        b_fa_alone = n_fa_alone;
    endtask

    task automatic sclk_bit(input logic b, output logic m);
        @(negedge clk); di = b;
        repeat (4) @(negedge clk);
        m = o_do;
        sclk = 1'b1;
        repeat (8) @(negedge clk);
        sclk = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic xfer(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        logic m;
        miso = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            sclk_bit(mosi[3'(7 - i)], m);
            miso[3'(7 - i)] = m;
        end
    endtask

    task automatic frame_begin();
        @(negedge clk); ncs = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic frame_finish();
        @(negedge clk); ncs = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; sclk = 1'b0; ncs = 1'b1; di = 1'b0; tx_data = 8'h00; tx_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (o_do !== 1'b1) begin n_fail++; $display("FAIL reset_do got %b want 1", o_do); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        n_checks++; if (selected !== 1'b0) begin n_fail++; $display("FAIL reset_selected got %b want 0", selected); end
        n_checks++;
        if ({rx_valid, tx_ack, frame_start, frame_end, frame_abort} !== 5'b0) begin
            n_fail++; $display("FAIL reset_pulses got %b want 00000",
                               {rx_valid, tx_ack, frame_start, frame_end, frame_abort});
        end
        @(negedge clk); rst = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_single_byte();
        logic [7:0] miso;
        snap();
        tx_valid = 1'b0;
        frame_begin();
        n_checks++; if (selected !== 1'b1) begin n_fail++; $display("FAIL single_selected got %b want 1", selected); end
        xfer(8'hA5, 8, miso);
        frame_finish();
        n_checks++; if (n_rxv - b_rxv != 1) begin n_fail++; $display("FAIL single_rxv_count got %0d want 1", n_rxv - b_rxv); end
        n_checks++; if (last_rx !== 8'hA5) begin n_fail++; $display("FAIL single_rx_data got %h want a5", last_rx); end
        n_checks++; if (last_first !== 1'b1) begin n_fail++; $display("FAIL single_rx_first got %b want 1", last_first); end
        n_checks++; if (miso !== 8'hFF) begin n_fail++; $display("FAIL single_miso got %h want ff", miso); end
        n_checks++; if (n_fs - b_fs != 1) begin n_fail++; $display("FAIL single_fs got %0d want 1", n_fs - b_fs); end
        n_checks++; if (n_fe - b_fe != 1) begin n_fail++; $display("FAIL single_fe got %0d want 1", n_fe - b_fe); end
        n_checks++; if (n_fa - b_fa != 0) begin n_fail++; $display("FAIL single_fa got %0d want 0", n_fa - b_fa); end
        n_checks++; if (n_ack - b_ack != 0) begin n_fail++; $display("FAIL single_ack got %0d want 0", n_ack - b_ack); end
    endtask

    task automatic test_three_bytes();
        logic [7:0] miso [3];
        logic [7:0] want [3];
        logic [7:0] mosi [3];
        int first_before;
        want = '{8'h3C, 8'h81, 8'h00};
        mosi = '{8'h01, 8'h02, 8'h03};
        snap();
        tx_data = 8'h3C; tx_valid = 1'b1;
        frame_begin();
        n_checks++; if (n_ack - b_ack != 1) begin n_fail++; $display("FAIL three_ack_at_fall got %0d want 1", n_ack - b_ack); end
        tx_data = 8'h81;
        xfer(mosi[0], 8, miso[0]);
        n_checks++; if (last_first !== 1'b1) begin n_fail++; $display("FAIL three_first0 got %b want 1", last_first); end
        first_before = n_rxv;
        tx_data = 8'h00;
        xfer(mosi[1], 8, miso[1]);
        n_checks++; if (last_first !== 1'b0 || last_rx !== 8'h02) begin
            n_fail++; $display("FAIL three_byte1 got %h/%b want 02/0", last_rx, last_first);
        end
        tx_valid = 1'b0;
        xfer(mosi[2], 8, miso[2]);
        n_checks++; if (last_first !== 1'b0 || last_rx !== 8'h03) begin
            n_fail++; $display("FAIL three_byte2 got %h/%b want 03/0", last_rx, last_first);
        end
        frame_finish();
        n_checks++; if (n_rxv - first_before != 2) begin n_fail++; $display("FAIL three_rxv_tail got %0d want 2", n_rxv - first_before); end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (miso[i] !== want[i]) begin n_fail++; $display("FAIL three_miso%0d got %h want %h", i, miso[i], want[i]); end
        end
        n_checks++; if (n_rxv - b_rxv != 3) begin n_fail++; $display("FAIL three_rxv got %0d want 3", n_rxv - b_rxv); end
        n_checks++; if (n_ack - b_ack != 3) begin n_fail++; $display("FAIL three_ack got %0d want 3", n_ack - b_ack); end
    endtask

    task automatic test_abort();
        logic [7:0] miso;
        snap();
        frame_begin();
        xfer(8'hF0, 5, miso);
        frame_finish();
        n_checks++; if (n_rxv - b_rxv != 0) begin n_fail++; $display("FAIL abort_rxv got %0d want 0", n_rxv - b_rxv); end
        n_checks++; if (n_fe - b_fe != 1) begin n_fail++; $display("FAIL abort_fe got %0d want 1", n_fe - b_fe); end
        n_checks++; if (n_fa - b_fa != 1) begin n_fail++; $display("FAIL abort_fa got %0d want 1", n_fa - b_fa); end
        n_checks++; if (n_fa_alone - b_fa_alone != 0) begin n_fail++; $display("FAIL abort_not_with_end got %0d want 0", n_fa_alone - b_fa_alone); end
        snap();
        frame_begin();
        xfer(8'h55, 8, miso);
        frame_finish();
        n_checks++; if (n_rxv - b_rxv != 1 || last_rx !== 8'h55 || last_first !== 1'b1) begin
            n_fail++; $display("FAIL abort_next_frame got n=%0d %h/%b want n=1 55/1", n_rxv - b_rxv, last_rx, last_first);
        end
        n_checks++; if (n_fa - b_fa != 0) begin n_fail++; $display("FAIL abort_next_fa got %0d want 0", n_fa - b_fa); end
    endtask

    task automatic test_deselected();
        int bad_do = 0;
        int bad_sel = 0;
        snap();
        ncs = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); sclk = ~sclk;
            repeat (6) begin
                @(negedge clk);
                if (o_do !== 1'b1) bad_do++;
                if (selected !== 1'b0) bad_sel++;
            end
        end
        sclk = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++; if (bad_do != 0) begin n_fail++; $display("FAIL desel_do got %0d low samples want 0", bad_do); end
        n_checks++; if (bad_sel != 0) begin n_fail++; $display("FAIL desel_selected got %0d high samples want 0", bad_sel); end
        n_checks++;
        if ((n_rxv - b_rxv) + (n_ack - b_ack) + (n_fs - b_fs) + (n_fe - b_fe) + (n_fa - b_fa) != 0) begin
            n_fail++; $display("FAIL desel_pulses got %0d want 0",
                               (n_rxv - b_rxv) + (n_ack - b_ack) + (n_fs - b_fs) + (n_fe - b_fe) + (n_fa - b_fa));
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] miso;
        frame_begin();
        xfer(8'h12, 3, miso);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (o_do !== 1'b1 || selected !== 1'b0 || rx_data !== 8'h00) begin
            n_fail++; $display("FAIL rstmid_during got do=%b sel=%b rx=%h want 1/0/00", o_do, selected, rx_data);
        end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(negedge clk);
        snap();
        xfer(8'h12, 8, miso);
        n_checks++; if (miso !== 8'hFF) begin n_fail++; $display("FAIL rstmid_do_after got %h want ff", miso); end
        n_checks++; if (n_rxv - b_rxv != 0) begin n_fail++; $display("FAIL rstmid_no_rxv got %0d want 0", n_rxv - b_rxv); end
        n_checks++; if (n_fs - b_fs != 0) begin n_fail++; $display("FAIL rstmid_no_fs got %0d want 0", n_fs - b_fs); end
        frame_finish();
        n_checks++; if (n_fe - b_fe != 0) begin n_fail++; $display("FAIL rstmid_no_fe got %0d want 0", n_fe - b_fe); end
        snap();
        frame_begin();
        xfer(8'h12, 8, miso);
        frame_finish();
        n_checks++; if (n_rxv - b_rxv != 1 || last_rx !== 8'h12 || last_first !== 1'b1) begin
            n_fail++; $display("FAIL rstmid_fresh got n=%0d %h/%b want n=1 12/1", n_rxv - b_rxv, last_rx, last_first);
        end
    endtask

    task automatic test_collision();
        logic [7:0] miso;
        snap();
        frame_begin();
        xfer(8'h7E, 7, miso);
        @(negedge clk); di = 1'b0;
        repeat (4) @(negedge clk);
        sclk = 1'b1; ncs = 1'b1;
        repeat (8) @(negedge clk);
        sclk = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++; if (n_rxv - b_rxv != 1 || last_rx !== 8'h7E) begin
            n_fail++; $display("FAIL collide_rx got n=%0d %h want n=1 7e", n_rxv - b_rxv, last_rx);
        end
        n_checks++; if (n_fe - b_fe != 1) begin n_fail++; $display("FAIL collide_fe got %0d want 1", n_fe - b_fe); end
        n_checks++; if (fe_cyc != rxv_cyc + 1) begin n_fail++; $display("FAIL collide_fe_delay got %0d want %0d", fe_cyc, rxv_cyc + 1); end
        n_checks++; if (n_fa - b_fa != 0) begin n_fail++; $display("FAIL collide_fa got %0d want 0", n_fa - b_fa); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_three_bytes();
        test_abort();
        test_deselected();
        test_reset_mid_frame();
        test_collision();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_slave_frontend.md
Name: spi_slave_frontend

Overview:
- Clock-domain front end for one SPI target slot. Synchronises the ESP32 master's sclk/ncs/di into clk and deserialises MOSI bytes into a valid-strobed byte stream.
- Serialises response bytes back onto do.
- Sits directly upstream of device_handler command decoding; one instance per module slot, fed by the decoded per-slot ncs.
- do idles high, so slot outputs can be wired-ANDed at top level.

Parameters:
- SYNC_STAGES, 2, flip-flop depth of the input synchronisers for sclk, ncs and di (minimum 2).
- IDLE_BYTE, 8'hFF, byte shifted out when no response byte is offered.

Ports:
- clk  input  1  system clock. Interface timing: one clock; reset is asynchronous and active-high.
- reset  input  1  asynchronous, active-high reset.
- sclk  input  1  SPI clock, asynchronous; mode 0 (CPOL=0, CPHA=0).
- ncs  input  1  slot select, active-low, asynchronous.
- di  input  1  MOSI, asynchronous.
- do  output  1  MISO; 1 when not selected.
- rx_data  output  8  last received byte, MSB first on the wire.
- rx_valid  output  1  one-clk pulse; rx_data is new.
- rx_first  output  1  qualifies rx_valid; byte is the first byte of the frame.
- tx_data  input  8  next response byte.
- tx_valid  input  1  tx_data is offered.
- tx_ack  output  1  one-clk pulse; tx_data was consumed.
- frame_start  output  1  one-clk pulse on synchronised ncs fall.
- frame_end  output  1  one-clk pulse on synchronised ncs rise.
- frame_abort  output  1  one-clk pulse with frame_end if the frame ended with 1..7 bits of a byte received.
- selected  output  1  synchronised, inverted ncs level.

Behaviour:
- Reset values:
  - do=1, rx_data=0, selected=0.
  - All pulse outputs 0.
  - bit_cnt=0; tx_shift=IDLE_BYTE.
  - Synchronisers load idle values: sclk=0, ncs=1, di=0.
- Synchronisation and edges:
  - Each input passes through SYNC_STAGES flops.
  - Edges are detected by comparing the last sync stage with one extra registered copy.
  - Detect latency: SYNC_STAGES+1 clk.
- Timing requirements on the master:
  - sclk high and low times each ≥ SYNC_STAGES+2 clk periods.
  - ncs fall to first sclk rise ≥ SYNC_STAGES+3 clk periods.
- States: IDLE, ACTIVE.
  - IDLE→ACTIVE on ncs fall: pulse frame_start; bit_cnt=0; set first flag.
  - On the same ncs-fall entry, load tx_shift: tx_data with a tx_ack pulse if tx_valid=1, else IDLE_BYTE.
  - ACTIVE→IDLE on ncs rise.
  - sclk edges are ignored in IDLE.
- sclk rise in ACTIVE:
  - rx_shift = {rx_shift[6:0], di_sync}; bit_cnt increments mod 8.
  - When bit_cnt was 7:
    - Next clk: rx_data = completed byte, rx_valid=1, rx_first=first flag; then clear first flag.
    - Same edge: reload tx_shift from tx_data/tx_valid (tx_ack on consume, else IDLE_BYTE).
- sclk fall in ACTIVE:
  - If bit_cnt≠0, tx_shift = {tx_shift[6:0],1'b1}.
  - bit_cnt=0 after wrap: no shift, so the new MSB stays on do.
- do = selected ? tx_shift[7] : 1.
- Boundary conditions:
  - ncs rise with bit_cnt≠0: partial bits discarded, no rx_valid, frame_end and frame_abort pulse together.
  - ncs rise with bit_cnt=0: frame_end only.
  - 8th sclk rise and ncs rise detected in the same clk: the rise is processed first. rx_valid is emitted and frame_end follows 1 clk later; no abort.
  - ncs fall while a pulse from the previous frame is still pending: not possible, because ncs high time ≥ SYNC_STAGES+2 clk is required.
  - No tx_valid at a byte boundary: IDLE_BYTE is sent, no tx_ack, and tx_data is not sampled later mid-byte.
  - Reset asserted mid-frame: everything returns to reset values immediately and do=1. After release, the block waits for a fresh ncs fall; it never resumes a frame on an already-low ncs.
  - Only one sclk edge can exist per clk (timing requirement), so rise/fall collisions are not handled.

Test Plan:
- Single byte, no tx: ncs low, send 0xA5, ncs high.
  - rx_valid once with rx_data=0xA5, rx_first=1.
  - do bits 1,1,1,1,1,1,1,1.
  - frame_start and frame_end pulse once each; frame_abort=0.
- Three bytes with tx: tx_valid=1 holding 0x3C, then 0x81, then 0x00.
  - MOSI 0x01,0x02,0x03 → rx_valid ×3, rx_first only on the first byte.
  - MISO reads 0x3C,0x81,0x00.
  - tx_ack ×3: at ncs fall, after byte 1, after byte 2.
- Abort: send 5 bits of 0xF0, then ncs high.
  - No rx_valid; frame_end=1 and frame_abort=1 on the same clk.
  - Next frame of 0x55 gives rx_data=0x55, rx_first=1.
- Deselected behaviour: toggle sclk 16 times with ncs high.
  - do=1 throughout; no pulses; selected=0.
- Reset mid-frame: assert reset after bit 3 while ncs is still low, release it, then clock 8 bits of 0x12.
  - do=1 during and after reset; no rx_valid until the next ncs fall.
  - Then 0x12 is received with rx_first=1.
- Edge collision: 8th sclk rise and ncs rise in the same synchronised clk.
  - rx_valid with 0x7E, frame_end 1 clk later, frame_abort=0.
